// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, tag encoding and CDB entry types for the result-writeback stage.
package cdb_arbiter_pkg;

    localparam int unsigned INST_TAG_WIDTH = 6;
    localparam int unsigned COMMON_WIDTH   = 32;

    localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '1;

    typedef struct packed {
        logic [INST_TAG_WIDTH-1:0] tag;
        logic [COMMON_WIDTH-1:0]   val;
    } cdb_entry_t;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_MEM = 1'b1
    } cdb_src_e;

    function automatic logic tag_valid(input logic [INST_TAG_WIDTH-1:0] t);
        return t != TAG_INVALID;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer/ROB-side signal bundle of the CDB arbiter; slave is the arbiter side.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [INST_TAG_WIDTH-1:0] alu_target;
    logic [COMMON_WIDTH-1:0]   alu_result;
    logic                      alu_stall;
    logic [INST_TAG_WIDTH-1:0] mem_target;
    logic [COMMON_WIDTH-1:0]   mem_result;
    logic                      mem_stall;
    logic                      rob_ready;
    logic                      cdb_valid;
    logic [INST_TAG_WIDTH-1:0] cdb_tag;
    logic [COMMON_WIDTH-1:0]   cdb_val;
    logic                      overflow;

    modport slave (
        input  alu_target, alu_result, mem_target, mem_result, rob_ready,
        output alu_stall, mem_stall, cdb_valid, cdb_tag, cdb_val, overflow
    );

    modport master (
        output alu_target, alu_result, mem_target, mem_result, rob_ready,
        input  alu_stall, mem_stall, cdb_valid, cdb_tag, cdb_val, overflow
    );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result FIFO (module result_fifo); push into a full FIFO is accepted only
// when a pop happens on the same edge.
module result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  cdb_entry_t      i_data,
    input  logic            i_pop,
    output cdb_entry_t      o_head,
    output logic [CntW-1:0] o_count,
    output logic            o_full
);

    cdb_entry_t      r_mem [DEPTH];
    logic [PtrW-1:0] r_head;
    logic [PtrW-1:0] r_tail;
    logic [CntW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CntW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_head];
    assign o_count   = r_count;

    // When full, tail equals head: the slot being popped is the one rewritten.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_do_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin writeback of ALU and memory results onto the single CDB/ROB write port.
// Optional same-cycle bypass when both FIFOs are empty: define CDB_BYPASS_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input logic          i_clk,
    input logic          i_rst,
    cdb_arbiter_if.slave io_bus
);

    localparam logic [CntW-1:0] StallLvl = CntW'(DEPTH - 1);

    cdb_entry_t      w_alu_in_data, w_mem_in_data, w_alu_head, w_mem_head;
    logic [CntW-1:0] w_alu_cnt, w_mem_cnt;
    logic            w_alu_full, w_mem_full;
    logic            w_alu_in, w_mem_in, w_alu_ne, w_mem_ne;
    logic            w_alu_push, w_mem_push, w_alu_pop, w_mem_pop;
    logic            w_fifo_valid, w_fifo_gnt_mem, w_byp_alu, w_byp_mem;
    cdb_src_e        w_gnt_src;
    cdb_src_e        r_last_grant;
    logic            r_overflow;

    assign w_alu_in_data = '{tag: io_bus.alu_target, val: io_bus.alu_result};
    assign w_mem_in_data = '{tag: io_bus.mem_target, val: io_bus.mem_result};
    assign w_alu_in      = tag_valid(io_bus.alu_target);
    assign w_mem_in      = tag_valid(io_bus.mem_target);
    assign w_alu_ne      = (w_alu_cnt != '0);
    assign w_mem_ne      = (w_mem_cnt != '0);

    assign w_fifo_valid   = io_bus.rob_ready && (w_alu_ne || w_mem_ne);
    assign w_fifo_gnt_mem = w_mem_ne && (!w_alu_ne || r_last_grant == CDB_SRC_ALU);

`ifdef CDB_BYPASS_EN
    logic w_byp_ok;
    assign w_byp_ok  = io_bus.rob_ready && !w_alu_ne && !w_mem_ne && !i_rst;
    assign w_byp_mem = w_byp_ok && w_mem_in && (!w_alu_in || r_last_grant == CDB_SRC_ALU);
    assign w_byp_alu = w_byp_ok && w_alu_in && !w_byp_mem;
`else
    assign w_byp_mem = 1'b0;
    assign w_byp_alu = 1'b0;
`endif

    always_comb begin
        io_bus.cdb_valid = 1'b0;
        io_bus.cdb_tag   = TAG_INVALID;
        io_bus.cdb_val   = '0;
        w_alu_pop        = 1'b0;
        w_mem_pop        = 1'b0;
        w_gnt_src        = CDB_SRC_ALU;
        if (w_fifo_valid) begin
            io_bus.cdb_valid = 1'b1;
            if (w_fifo_gnt_mem) begin
                {io_bus.cdb_tag, io_bus.cdb_val} = w_mem_head;
                w_mem_pop = 1'b1;
                w_gnt_src = CDB_SRC_MEM;
            end else begin
                {io_bus.cdb_tag, io_bus.cdb_val} = w_alu_head;
                w_alu_pop = 1'b1;
            end
        end else if (w_byp_alu) begin
            io_bus.cdb_valid = 1'b1;
            {io_bus.cdb_tag, io_bus.cdb_val} = w_alu_in_data;
        end else if (w_byp_mem) begin
            io_bus.cdb_valid = 1'b1;
            {io_bus.cdb_tag, io_bus.cdb_val} = w_mem_in_data;
            w_gnt_src = CDB_SRC_MEM;
        end
    end

    assign w_alu_push = w_alu_in && !w_byp_alu;
    assign w_mem_push = w_mem_in && !w_byp_mem;

    result_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_alu_push),
        .i_data  (w_alu_in_data),
        .i_pop   (w_alu_pop),
        .o_head  (w_alu_head),
        .o_count (w_alu_cnt),
        .o_full  (w_alu_full)
    );

    result_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_mem_push),
        .i_data  (w_mem_in_data),
        .i_pop   (w_mem_pop),
        .o_head  (w_mem_head),
        .o_count (w_mem_cnt),
        .o_full  (w_mem_full)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= CDB_SRC_MEM;
            r_overflow   <= 1'b0;
        end else begin
            if (io_bus.cdb_valid) begin
                r_last_grant <= w_gnt_src;
            end
            if ((w_alu_push && w_alu_full && !w_alu_pop) ||
                (w_mem_push && w_mem_full && !w_mem_pop)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign io_bus.overflow  = r_overflow;
    assign io_bus.alu_stall = (w_alu_cnt >= StallLvl);
    assign io_bus.mem_stall = (w_mem_cnt >= StallLvl);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised and directed bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

    cdb_arbiter #(.DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    cdb_entry_t q_alu[$];
    cdb_entry_t q_mem[$];
    bit         m_last_mem;
    bit         m_ovf;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q_alu.delete();
        q_mem.delete();
        m_last_mem = 1'b1;
        m_ovf      = 1'b0;
    endtask

    // One cycle: drive, compare combinational outputs against the model, advance the model.
    task automatic step(input bit a_v, input logic [5:0] a_t, input logic [31:0] a_d,
                        input bit m_v, input logic [5:0] m_t, input logic [31:0] m_d,
                        input bit rdy, input bit rs);
        bit         ev, pop_alu, pop_mem, byp_alu, byp_mem;
        cdb_entry_t exp;
        @(negedge clk);
        rst            = rs;
        bus.alu_target = a_v ? a_t : TAG_INVALID;
        bus.alu_result = a_d;
        bus.mem_target = m_v ? m_t : TAG_INVALID;
        bus.mem_result = m_d;
        bus.rob_ready  = rdy;
        #2;
        ev = 0; pop_alu = 0; pop_mem = 0; byp_alu = 0; byp_mem = 0;
        exp = '{tag: TAG_INVALID, val: '0};
        if (rdy && (q_alu.size() > 0 || q_mem.size() > 0)) begin
            ev = 1;
            if (q_mem.size() > 0 && (q_alu.size() == 0 || !m_last_mem)) begin
                pop_mem = 1; exp = q_mem[0];
            end else begin
                pop_alu = 1; exp = q_alu[0];
            end
        end
`ifdef CDB_BYPASS_EN
        else if (rdy && !rs && (a_v || m_v)) begin
            ev = 1;
            if (m_v && (!a_v || !m_last_mem)) begin
                byp_mem = 1; exp = '{tag: m_t, val: m_d};
            end else begin
                byp_alu = 1; exp = '{tag: a_t, val: a_d};
            end
        end
`endif
        check_eq("cdb_valid", 64'(bus.cdb_valid), 64'(ev));
        check_eq("cdb_tag",   64'(bus.cdb_tag),   64'(exp.tag));
        check_eq("cdb_val",   64'(bus.cdb_val),   64'(exp.val));
        check_eq("alu_stall", 64'(bus.alu_stall), 64'(q_alu.size() >= DEPTH - 1));
        check_eq("mem_stall", 64'(bus.mem_stall), 64'(q_mem.size() >= DEPTH - 1));
        check_eq("overflow",  64'(bus.overflow),  64'(m_ovf));
        if (rs) begin
            model_reset();
        end else begin
            if (pop_alu) void'(q_alu.pop_front());
            if (pop_mem) void'(q_mem.pop_front());
            if (pop_alu || byp_alu) m_last_mem = 1'b0;
            if (pop_mem || byp_mem) m_last_mem = 1'b1;
            if (a_v && !byp_alu) begin
                if (q_alu.size() < DEPTH) q_alu.push_back('{tag: a_t, val: a_d});
                else m_ovf = 1'b1;
            end
            if (m_v && !byp_mem) begin
                if (q_mem.size() < DEPTH) q_mem.push_back('{tag: m_t, val: m_d});
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int unsigned rdy_pct;
        rst            = 1'b1;
        bus.alu_target = TAG_INVALID;
        bus.alu_result = '0;
        bus.mem_target = TAG_INVALID;
        bus.mem_result = '0;
        bus.rob_ready  = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Single ALU result; bypass shows it the same cycle, otherwise one cycle later.
        step(1, 6'd3, 32'h10, 0, 0, 0, 1, 0);
        idle(1);
        idle(1);

        // Contention: expected CDB order 1,5,2,6.
        do_reset();
        step(1, 6'd1, 32'hA1, 1, 6'd5, 32'hB5, 1, 0);
        step(1, 6'd2, 32'hA2, 1, 6'd6, 32'hB6, 1, 0);
        repeat (4) idle(1);

        // Fill ALU FIFO with the ROB stalled, overflow on the fifth push.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 6'(10 + i), 32'(100 + i), 0, 0, 0, 0, 0);
        idle(0);
        // Full FIFO with simultaneous pop and push.
        step(1, 6'd20, 32'h200, 0, 0, 0, 1, 0);
        repeat (5) idle(1);

        // Reset with both FIFOs holding two entries.
        do_reset();
        step(1, 6'd1, 32'h1, 1, 6'd2, 32'h2, 0, 0);
        step(1, 6'd3, 32'h3, 1, 6'd4, 32'h4, 0, 0);
        do_reset();
        idle(1);

        // Post-reset tie: ALU wins.
        step(1, 6'd7, 32'h77, 1, 6'd9, 32'h99, 1, 0);
        repeat (3) idle(1);

        for (int blk = 0; blk < 8; blk++) begin
            rdy_pct = (blk % 2 == 0) ? 90 : 35;
            for (int c = 0; c < 100; c++) begin
                bit rs;
                rs = ($urandom_range(0, 99) < 2);
                step(!rs && ($urandom_range(0, 99) < 55), 6'($urandom_range(0, 62)), $urandom,
                     !rs && ($urandom_range(0, 99) < 45), 6'($urandom_range(0, 62)), $urandom,
                     ($urandom_range(0, 99) < rdy_pct), rs);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
